iob_axi_mem_resp: RTL and testbench

AXI4 slave memory responder: services INCR read and write bursts issued by AXI masters such as the DMA engine's AXI port, backed by an internal word-addressed RAM. Used as the memory-side endpoint in DMA simulation benches and as on-chip scratch memory behind an interconnect. Read and write channels run independently, each at one beat per cycle.

---
 rtl/iob_axi_mem_resp.sv | 243 ++++++++++++++++++++++++
 tb/tb_iob_axi_mem_resp.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi_mem_resp.sv
// rtl/iob_axi_mem_resp.sv - AXI4 INCR-burst slave memory responder backed by a word-addressed RAM.
// Optional byte-strobe writes are enabled by defining IOB_AXI_MEM_RESP_WSTRB_EN.
module iob_axi_mem_resp #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cke_i,

  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic [3:0]              axi_awqos_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,

  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,

  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,

  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic                    axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [2:0]              axi_arprot_i,
  input  logic [3:0]              axi_arqos_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,

  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam int NB    = AXI_DATA_W / 8;
  localparam int B     = $clog2(NB);
  localparam int DEPTH = 1 << MEM_ADDR_W;
  localparam logic [MEM_ADDR_W-1:0] IDX_ONE = 1;
  localparam logic [AXI_LEN_W-1:0]  CNT_ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t              r_wstate;
  logic [MEM_ADDR_W-1:0] r_widx;
  logic [AXI_LEN_W-1:0]  r_wcnt;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [AXI_ID_W-1:0]   r_bid;

  r_state_t              r_rstate;
  logic [MEM_ADDR_W-1:0] r_ridx;
  logic [AXI_LEN_W-1:0]  r_rcnt;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [AXI_ID_W-1:0]   r_rid;
  logic [AXI_DATA_W-1:0] r_rdata;

  logic [AXI_DATA_W-1:0] r_mem [DEPTH];

  logic                  w_we;
  logic                  w_re;
  logic [MEM_ADDR_W-1:0] w_raddr;
  logic                  w_unused;

  // Write channel: wlast is deliberately ignored, the latched beat count ends the burst.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wstate  <= W_IDLE;
      r_widx    <= '0;
      r_wcnt    <= '0;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
    end else if (cke_i) begin
      case (r_wstate)
        W_IDLE: begin
          if (axi_awvalid_i) begin
            r_widx    <= axi_awaddr_i[MEM_ADDR_W+B-1:B];
            r_wcnt    <= axi_awlen_i;
            r_bid     <= axi_awid_i;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi_wvalid_i) begin
            r_widx <= r_widx + IDX_ONE;
            r_wcnt <= r_wcnt - CNT_ONE;
            if (r_wcnt == '0) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready_i) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_wstate  <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rstate  <= R_IDLE;
      r_ridx    <= '0;
      r_rcnt    <= '0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
    end else if (cke_i) begin
      case (r_rstate)
        R_IDLE: begin
          if (axi_arvalid_i) begin
            r_ridx    <= axi_araddr_i[MEM_ADDR_W+B-1:B];
            r_rcnt    <= axi_arlen_i;
            r_rid     <= axi_arid_i;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (axi_arlen_i == '0);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rready_i) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= r_ridx + IDX_ONE;
              r_rcnt  <= r_rcnt - CNT_ONE;
              r_rlast <= (r_rcnt == CNT_ONE);
            end
          end
        end
        default: begin
          r_arready <= 1'b1;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
          r_rstate  <= R_IDLE;
        end
      endcase
    end
  end

  // Prefetch the next word on a handshake, otherwise re-read the current one so rdata holds under stall.
  always_comb begin
    w_re    = 1'b0;
    w_raddr = r_ridx;
    if (r_rstate == R_IDLE) begin
      w_re    = axi_arvalid_i;
      w_raddr = axi_araddr_i[MEM_ADDR_W+B-1:B];
    end else begin
      w_re = 1'b1;
      if (axi_rready_i) begin
        w_raddr = r_ridx + IDX_ONE;
      end
    end
  end

  assign w_we = cke_i & r_wready & axi_wvalid_i;

  always_ff @(posedge clk_i) begin
    if (w_we) begin
`ifdef IOB_AXI_MEM_RESP_WSTRB_EN
      for (int i = 0; i < NB; i++) begin
        if (axi_wstrb_i[i]) begin
          r_mem[r_widx][i*8 +: 8] <= axi_wdata_i[i*8 +: 8];
        end
      end
`else
      r_mem[r_widx] <= axi_wdata_i;
`endif
    end
  end

  // Separate block from the array write so a same-cycle read of the written word returns old data.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rdata <= '0;
    end else if (cke_i && w_re) begin
      r_rdata <= r_mem[w_raddr];
    end
  end

  assign axi_awready_o = r_awready;
  assign axi_wready_o  = r_wready;
  assign axi_bvalid_o  = r_bvalid;
  assign axi_bid_o     = r_bid;
  assign axi_bresp_o   = 2'b00;
  assign axi_arready_o = r_arready;
  assign axi_rvalid_o  = r_rvalid;
  assign axi_rlast_o   = r_rlast;
  assign axi_rid_o     = r_rid;
  assign axi_rdata_o   = r_rdata;
  assign axi_rresp_o   = 2'b00;

  assign w_unused = ^{axi_awsize_i, axi_awburst_i, axi_awlock_i, axi_awcache_i, axi_awprot_i,
                      axi_awqos_i, axi_arsize_i, axi_arburst_i, axi_arlock_i, axi_arcache_i,
                      axi_arprot_i, axi_arqos_i, axi_wlast_i, axi_wstrb_i, axi_awaddr_i,
                      axi_araddr_i, r_rcnt};

endmodule

// File: tb/tb_iob_axi_mem_resp.sv
// tb/tb_iob_axi_mem_resp.sv - randomized self-checking bench for iob_axi_mem_resp.
// Expectations come from a transaction-level memory model; build with IOB_AXI_MEM_RESP_WSTRB_EN to match the DUT.
module tb_iob_axi_mem_resp;
  localparam int DEPTH = 1024;

  logic        clk_i  = 1'b0;
  logic        arst_i = 1'b1;
  logic        cke_i  = 1'b1;

  logic [0:0]  axi_awid = '0;
  logic [23:0] axi_awaddr = '0;
  logic [7:0]  axi_awlen = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready_o;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wlast = 1'b0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready_o;
  logic [0:0]  axi_bid_o;
  logic [1:0]  axi_bresp_o;
  logic        axi_bvalid_o;
  logic        axi_bready = 1'b0;
  logic [0:0]  axi_arid = '0;
  logic [23:0] axi_araddr = '0;
  logic [7:0]  axi_arlen = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready_o;
  logic [0:0]  axi_rid_o;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic        axi_rlast_o;
  logic        axi_rvalid_o;
  logic        axi_rready = 1'b0;

  iob_axi_mem_resp dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
    .axi_awid_i(axi_awid), .axi_awaddr_i(axi_awaddr), .axi_awlen_i(axi_awlen),
    .axi_awsize_i(3'd2), .axi_awburst_i(2'b01), .axi_awlock_i(1'b0), .axi_awcache_i(4'd0),
    .axi_awprot_i(3'd0), .axi_awqos_i(4'd0), .axi_awvalid_i(axi_awvalid), .axi_awready_o(axi_awready_o),
    .axi_wdata_i(axi_wdata), .axi_wstrb_i(axi_wstrb), .axi_wlast_i(axi_wlast),
    .axi_wvalid_i(axi_wvalid), .axi_wready_o(axi_wready_o),
    .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready),
    .axi_arid_i(axi_arid), .axi_araddr_i(axi_araddr), .axi_arlen_i(axi_arlen),
    .axi_arsize_i(3'd2), .axi_arburst_i(2'b01), .axi_arlock_i(1'b0), .axi_arcache_i(4'd0),
    .axi_arprot_i(3'd0), .axi_arqos_i(4'd0), .axi_arvalid_i(axi_arvalid), .axi_arready_o(axi_arready_o),
    .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: memory image plus the outstanding write/read transaction of each channel.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          w_act, w_resp, r_act;
  int          w_left, w_idx, r_base;
  logic [0:0]  w_id, r_id;
  logic [31:0] r_q [$];
  bit          r_kq [$];

  always @(negedge clk_i) begin
    if (arst_i) begin
      w_act = 0; w_resp = 0; r_act = 0;
      r_q.delete(); r_kq.delete();
      chk("rst_awready", axi_awready_o, 1);
      chk("rst_wready",  axi_wready_o, 0);
      chk("rst_bvalid",  axi_bvalid_o, 0);
      chk("rst_bid",     axi_bid_o, 0);
      chk("rst_bresp",   axi_bresp_o, 0);
      chk("rst_arready", axi_arready_o, 1);
      chk("rst_rvalid",  axi_rvalid_o, 0);
      chk("rst_rlast",   axi_rlast_o, 0);
      chk("rst_rid",     axi_rid_o, 0);
      chk("rst_rdata",   axi_rdata_o, 0);
      chk("rst_rresp",   axi_rresp_o, 0);
    end else begin
      chk("awready", axi_awready_o, !(w_act || w_resp));
      chk("wready",  axi_wready_o, w_act);
      chk("bvalid",  axi_bvalid_o, w_resp);
      if (w_resp) begin
        chk("bid",   axi_bid_o, w_id);
        chk("bresp", axi_bresp_o, 0);
      end
      chk("arready", axi_arready_o, !r_act);
      chk("rvalid",  axi_rvalid_o, r_act);
      if (r_act) begin
        chk("rlast", axi_rlast_o, r_q.size() == 1);
        chk("rid",   axi_rid_o, r_id);
        chk("rresp", axi_rresp_o, 0);
        if (r_kq[0]) chk("rdata", axi_rdata_o, r_q[0]);
      end
      if (cke_i) begin
        // Read channel first: a beat snapshot taken this cycle sees memory before this cycle's write.
        if (r_act) begin
          if (axi_rready) begin
            void'(r_q.pop_front());
            void'(r_kq.pop_front());
            if (r_q.size() == 0) r_act = 0;
          end
        end else if (axi_arvalid) begin
          r_act  = 1;
          r_id   = axi_arid;
          r_base = (int'(axi_araddr) >> 2) % DEPTH;
          for (int k = 0; k <= int'(axi_arlen); k++) begin
            r_q.push_back(m_mem[(r_base + k) % DEPTH]);
            r_kq.push_back(m_known[(r_base + k) % DEPTH]);
          end
        end
        if (w_resp) begin
          if (axi_bready) w_resp = 0;
        end else if (w_act) begin
          if (axi_wvalid) begin
`ifdef IOB_AXI_MEM_RESP_WSTRB_EN
            for (int b = 0; b < 4; b++)
              if (axi_wstrb[b]) m_mem[w_idx][8*b +: 8] = axi_wdata[8*b +: 8];
            m_known[w_idx] = m_known[w_idx] || (axi_wstrb == 4'hF);
`else
            m_mem[w_idx]   = axi_wdata;
            m_known[w_idx] = 1;
`endif
            w_idx = (w_idx + 1) % DEPTH;
            if (w_left == 0) begin
              w_act  = 0;
              w_resp = 1;
            end else begin
              w_left--;
            end
          end
        end else if (axi_awvalid) begin
          w_act  = 1;
          w_left = int'(axi_awlen);
          w_idx  = (int'(axi_awaddr) >> 2) % DEPTH;
          w_id   = axi_awid;
        end
      end
    end
  end

  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];
  logic [31:0] rd_got [$];
  bit          cke_rand = 0;

  initial forever begin
    @(posedge clk_i);
    #1;
    cke_i = cke_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
  end

  task automatic wr_burst(input logic [23:0] a, input int len, input logic [0:0] id,
                          input int bhold, input bit gaps, input bit chk_lat);
    int guard = 0;
    int beat = 0;
    int waited = 0;
    bit hs;
    axi_awaddr = a; axi_awlen = 8'(len); axi_awid = id; axi_awvalid = 1'b1;
    do begin
      @(negedge clk_i); hs = axi_awready_o && cke_i;
      @(posedge clk_i); #1; guard++;
    end while (!hs && guard < 200);
    axi_awvalid = 1'b0;
    while (beat <= len && guard < 4000) begin
      axi_wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi_wdata  = wr_data[beat];
      axi_wstrb  = wr_strb[beat];
      axi_wlast  = (beat == len);
      @(negedge clk_i);
      if (chk_lat && beat == 0) chk("wready_lat", axi_wready_o, 1);
      hs = axi_wvalid && axi_wready_o && cke_i;
      @(posedge clk_i); #1; guard++;
      if (hs) beat++;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    do begin
      axi_bready = (waited >= bhold);
      @(negedge clk_i);
      if (chk_lat && waited == 0) chk("bvalid_lat", axi_bvalid_o, 1);
      hs = axi_bvalid_o && axi_bready && cke_i;
      @(posedge clk_i); #1; guard++; waited++;
    end while (!hs && guard < 4000);
    axi_bready = 1'b0;
    if (guard >= 4000) chk("wr_timeout", 1, 0);
  endtask

  task automatic rd_burst(input logic [23:0] a, input int len, input int mode);
    int guard = 0;
    bit hs;
    rd_got.delete();
    axi_araddr = a; axi_arlen = 8'(len); axi_arid = 1'($urandom); axi_arvalid = 1'b1;
    do begin
      @(negedge clk_i); hs = axi_arready_o && cke_i;
      @(posedge clk_i); #1; guard++;
    end while (!hs && guard < 200);
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    while (rd_got.size() < len + 1 && guard < 4000) begin
      case (mode)
        0:       axi_rready = 1'b1;
        1:       axi_rready = ~axi_rready;
        default: axi_rready = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk_i);
      if (axi_rvalid_o && axi_rready && cke_i) rd_got.push_back(axi_rdata_o);
      @(posedge clk_i); #1; guard++;
    end
    axi_rready = 1'b0;
    if (guard >= 4000) chk("rd_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    logic [23:0] a;
    repeat (2) @(posedge clk_i);
    #1 arst_i = 1'b0;

    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      wr_burst(24'(blk * 1024), 255, 1'b0, 0, 0, 0);
    end

    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + i; wr_strb[i] = 4'hF; end
    wr_burst(24'h10, 3, 1'b1, 0, 0, 1);
    rd_burst(24'h10, 3, 0);
    chk("t1_len", rd_got.size(), 4);
    chk("t1_b0", rd_got[0], 32'hA0);
    chk("t1_b1", rd_got[1], 32'hA1);
    chk("t1_b2", rd_got[2], 32'hA2);
    chk("t1_b3", rd_got[3], 32'hA3);

    rd_burst(24'h40, 7, 1);
    chk("toggle_len", rd_got.size(), 8);

    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hC0 + i; wr_strb[i] = 4'hF; end
    wr_burst(24'hFF8, 3, 1'b0, 1, 0, 0);
    rd_burst(24'h0, 1, 0);
    chk("wrap_b0", rd_got[0], 32'hC2);
    chk("wrap_b1", rd_got[1], 32'hC3);

    wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
    wr_burst(24'h100, 0, 1'b0, 0, 0, 0);
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'b0101;
    wr_burst(24'h100, 0, 1'b1, 0, 0, 0);
    rd_burst(24'h100, 0, 0);
`ifdef IOB_AXI_MEM_RESP_WSTRB_EN
    chk("strb_word", rd_got[0], 32'hFF22FF44);
`else
    chk("strb_word", rd_got[0], 32'h11223344);
`endif

    for (int i = 0; i < 16; i++) begin wr_data[i] = 32'h5000 + i; wr_strb[i] = 4'hF; end
    fork
      wr_burst(24'h190, 15, 1'b1, 5, 0, 0);
      rd_burst(24'h7D0, 15, 0);
    join
    chk("conc_len", rd_got.size(), 16);

    for (int i = 0; i < 8; i++) begin wr_data[i] = 32'h7700 + i; wr_strb[i] = 4'hF; end
    axi_awaddr = 24'h200; axi_awlen = 8'd7; axi_awid = 1'b1; axi_awvalid = 1'b1;
    @(posedge clk_i); #1;
    axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axi_wvalid = 1'b1; axi_wdata = wr_data[i]; axi_wstrb = 4'hF;
      @(posedge clk_i); #1;
    end
    arst_i = 1'b1; axi_wvalid = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_awready", axi_awready_o, 1);
    chk("mid_rst_wready", axi_wready_o, 0);
    chk("mid_rst_bvalid", axi_bvalid_o, 0);
    @(posedge clk_i); #1 arst_i = 1'b0;
    wr_burst(24'h220, 2, 1'b0, 0, 0, 0);
    rd_burst(24'h220, 2, 0);
    chk("post_rst_b2", rd_got[2], 32'h7702);

    cke_rand = 1;
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(0, 15);
      a   = 24'($urandom);
      for (int i = 0; i <= len; i++) begin
        wr_data[i] = $urandom;
        wr_strb[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
      wr_burst(a, len, 1'($urandom), $urandom_range(0, 3), 1, 0);
      rd_burst(a, len, 2);
      chk("rand_len", rd_got.size(), len + 1);
    end
    cke_rand = 0;
    repeat (3) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
